// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the mm:ss BCD stopwatch. It conditions the raw switches and
// buttons, derives the count strobe and issues single-cycle clear/tick/load commands.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dip_enable,
  input  logic       dip_up,
  input  logic       push_reset,
  input  logic       push_add5,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  output logic       cnt_clr,
  output logic       cnt_tick,
  output logic       cnt_up,
  output logic       load_min,
  output logic [3:0] load_min_ones,
  output logic [3:0] load_min_tens,
  output logic       state_run
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PAUSE = 3'd0,
    S_RUN   = 3'd1,
    S_DONE  = 3'd2,
    S_CLEAR = 3'd3,
    S_ADD   = 3'd4
  } state_t;

  state_t state_reg, state_next, ret_reg;

  logic [3:0] raw_in, sync1_reg, sync2_reg;
  logic       en_s, up_s;
  logic [1:0] press;
  logic       ev_clr, ev_add;
  logic       pend_clr_reg, pend_add_reg;
  logic       up_reg;
  logic [PW-1:0] pre_reg;
  logic       strobe, terminal;
  logic [3:0] ones_sum, tens_sum, add_ones, add_tens;
  logic       ones_carry;
  logic [3:0] load_ones_reg, load_tens_reg;

  // Bit order: 0 enable, 1 up, 2 reset button, 3 add5 button.
  assign raw_in = {push_add5, push_reset, dip_up, dip_enable};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign en_s = sync2_reg[0];
  assign up_s = sync2_reg[1];

  // press[0] = reset button, press[1] = add5 button; one cycle after the stable level rises.
  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic          btn_s;
    logic          stable_reg, rise_reg;
    logic [DW-1:0] cnt_reg;

    assign btn_s = sync2_reg[2+gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable_reg <= 1'b0;
        rise_reg   <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        rise_reg <= 1'b0;
        if (btn_s != stable_reg) begin
          if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
            stable_reg <= btn_s;
            rise_reg   <= btn_s;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end
    end

    assign press[gi] = rise_reg;
  end

  // Phase is held while disabled so a pause does not lose the partial second.
  assign strobe = en_s && (pre_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg <= '0;
    end else if (state_reg == S_CLEAR) begin
      pre_reg <= '0;
    end else if (en_s) begin
      pre_reg <= strobe ? '0 : pre_reg + 1'b1;
    end
  end

  assign terminal = up_reg ?
      (min_tens == 4'd5 && min_ones == 4'd9 && sec_tens == 4'd5 && sec_ones == 4'd9) :
      (min_tens == 4'd0 && min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd0);

  // Digit-wise BCD add of 5 minutes, saturating at 59.
  assign ones_sum   = min_ones + 4'd5;
  assign ones_carry = (ones_sum >= 4'd10);
  assign tens_sum   = min_tens + {3'b000, ones_carry};

  always_comb begin
    add_ones = ones_carry ? (ones_sum - 4'd10) : ones_sum;
    add_tens = tens_sum;
    if (tens_sum > 4'd5) begin
      add_tens = 4'd5;
      add_ones = 4'd9;
    end
  end

  assign ev_clr = press[0] | pend_clr_reg;
  assign ev_add = press[1] | pend_add_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_PAUSE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_PAUSE, S_RUN, S_DONE: begin
        if (ev_clr) begin
          state_next = S_CLEAR;
        end else if (ev_add) begin
          state_next = S_ADD;
        end else if (state_reg == S_PAUSE) begin
          if (en_s) state_next = S_RUN;
        end else if (!en_s) begin
          state_next = S_PAUSE;
        end else if (state_reg == S_RUN) begin
          if (strobe && terminal) state_next = S_DONE;
        end else if (!terminal) begin
          state_next = S_RUN;
        end
      end
      S_CLEAR: state_next = en_s ? S_RUN : S_PAUSE;
      S_ADD: begin
        if (!en_s)                             state_next = S_PAUSE;
        else if (ret_reg == S_DONE && terminal) state_next = S_DONE;
        else                                   state_next = S_RUN;
      end
      default: state_next = S_PAUSE;
    endcase
  end

  // Presses landing in a command cycle are parked and replayed in the following state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_reg       <= S_PAUSE;
      pend_clr_reg  <= 1'b0;
      pend_add_reg  <= 1'b0;
      load_ones_reg <= '0;
      load_tens_reg <= '0;
      up_reg        <= 1'b0;
    end else begin
      up_reg <= up_s;
      if (state_reg == S_CLEAR || state_reg == S_ADD) begin
        pend_clr_reg <= press[0];
        pend_add_reg <= press[1];
      end else begin
        pend_clr_reg <= 1'b0;
        pend_add_reg <= 1'b0;
        if (!ev_clr && ev_add) begin
          ret_reg       <= state_reg;
          load_ones_reg <= add_ones;
          load_tens_reg <= add_tens;
        end
      end
    end
  end

  always_comb begin
    cnt_clr       = 1'b0;
    cnt_tick      = 1'b0;
    load_min      = 1'b0;
    load_min_ones = 4'd0;
    load_min_tens = 4'd0;
    state_run     = 1'b0;
    cnt_up        = up_reg;
    case (state_reg)
      S_CLEAR: cnt_clr = 1'b1;
      S_ADD: begin
        load_min      = 1'b1;
        load_min_ones = load_ones_reg;
        load_min_tens = load_tens_reg;
      end
      S_RUN: begin
        state_run = 1'b1;
        cnt_tick  = strobe && !terminal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a time-in-seconds counter chain plus a rule-level reference
// model, driven by directed scenarios followed by random switch/button activity.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int MP = 0, MR = 1, MD = 2, MC = 3, MA = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dip_enable = 1'b0, dip_up = 1'b0, push_reset = 1'b0, push_add5 = 1'b0;
  logic [3:0] sec_ones = 4'd0, sec_tens = 4'd0, min_ones = 4'd0, min_tens = 4'd0;
  logic cnt_clr, cnt_tick, cnt_up, load_min, state_run;
  logic [3:0] load_min_ones, load_min_tens;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset),
    .dip_enable(dip_enable), .dip_up(dip_up), .push_reset(push_reset), .push_add5(push_add5),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .cnt_clr(cnt_clr), .cnt_tick(cnt_tick), .cnt_up(cnt_up), .load_min(load_min),
    .load_min_ones(load_min_ones), .load_min_tens(load_min_tens), .state_run(state_run)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int t = 0;                       // counter-chain time in seconds, 0..3599
  int cyc = 0;
  int obs_tick, obs_clr, obs_load, obs_lo, obs_lt, load_cyc, clr_cyc, tick_after_clr;

  // Reference model state
  logic [3:0] raw_q[$];
  bit  m_stable[2];
  int  m_run[2];
  bit  m_press[2];
  int  m_mode, m_ret, m_phase, m_load;
  bit  m_pend_c, m_pend_a;
  bit  x_clr, x_tick, x_up, x_load, x_run;
  int  x_lo, x_lt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic logic [3:0] synced_now();
    if (raw_q.size() >= 2) return raw_q[raw_q.size()-2];
    return 4'b0000;
  endfunction

  function automatic bit up_now();
    logic [3:0] v;
    if (raw_q.size() < 3) return 1'b0;
    v = raw_q[raw_q.size()-3];
    return v[1];
  endfunction

  function automatic bit is_terminal(input int tt, input bit up);
    return up ? (tt == 3599) : (tt == 0);
  endfunction

  task automatic model_reset();
    raw_q.delete();
    for (int b = 0; b < 2; b++) begin
      m_stable[b] = 1'b0; m_run[b] = 0; m_press[b] = 1'b0;
    end
    m_mode = MP; m_ret = MP; m_phase = 0; m_load = 0;
    m_pend_c = 1'b0; m_pend_a = 1'b0;
  endtask

  task automatic model_outputs();
    logic [3:0] sy;
    sy     = synced_now();
    x_up   = up_now();
    x_clr  = (m_mode == MC);
    x_load = (m_mode == MA);
    x_run  = (m_mode == MR);
    x_lt   = x_load ? m_load / 10 : 0;
    x_lo   = x_load ? m_load % 10 : 0;
    x_tick = x_run && sy[0] && (m_phase == TICK_DIV-1) && !is_terminal(t, x_up);
  endtask

  task automatic model_step();
    logic [3:0] sy;
    bit en, up, term, strobe, pc, pa, ec, ea;
    int old_mode;
    sy = synced_now();
    en = sy[0];
    up = up_now();
    term = is_terminal(t, up);
    strobe = en && (m_phase == TICK_DIV-1);
    pc = m_press[0];
    pa = m_press[1];
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 1'b0;
      if (sy[2+b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stable[b] = sy[2+b];
          m_press[b]  = sy[2+b];
          m_run[b]    = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    old_mode = m_mode;
    if (m_mode == MC || m_mode == MA) begin
      m_pend_c |= pc;
      m_pend_a |= pa;
      if (m_mode == MC)             m_mode = en ? MR : MP;
      else if (!en)                 m_mode = MP;
      else if (m_ret == MD && term) m_mode = MD;
      else                          m_mode = MR;
    end else begin
      ec = pc | m_pend_c;
      ea = pa | m_pend_a;
      m_pend_c = 1'b0;
      m_pend_a = 1'b0;
      if (ec) m_mode = MC;
      else if (ea) begin
        m_ret  = m_mode;
        m_load = (t / 60 + 5 > 59) ? 59 : t / 60 + 5;
        m_mode = MA;
      end
      else if (m_mode == MP) begin
        if (en) m_mode = MR;
      end
      else if (!en) m_mode = MP;
      else if (m_mode == MR && strobe && term) m_mode = MD;
      else if (m_mode == MD && !term) m_mode = MR;
    end
    if (old_mode == MC) m_phase = 0;
    else if (en) m_phase = (m_phase + 1) % TICK_DIV;
    raw_q.push_back({push_add5, push_reset, dip_up, dip_enable});
    if (raw_q.size() > 4) void'(raw_q.pop_front());
  endtask

  task automatic drive_digits();
    sec_ones = 4'((t % 60) % 10);
    sec_tens = 4'((t % 60) / 10);
    min_ones = 4'((t / 60) % 10);
    min_tens = 4'((t / 60) / 10);
  endtask

  task automatic clear_obs();
    obs_tick = 0; obs_clr = 0; obs_load = 0; obs_lo = -1; obs_lt = -1;
    load_cyc = -1; clr_cyc = -1; tick_after_clr = -1;
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic step_cycle();
    bit e_clr, e_tick, e_up, e_load;
    int e_lv;
    drive_digits();
    model_outputs();
    e_clr = x_clr; e_tick = x_tick; e_up = x_up; e_load = x_load; e_lv = m_load;
    @(posedge clk);
    model_step();
    if (e_clr)       t = 0;
    else if (e_tick) t = e_up ? (t + 1) % 3600 : (t + 3599) % 3600;
    else if (e_load) t = e_lv * 60 + t % 60;
    #1;
    drive_digits();
    @(negedge clk);
    cyc++;
    model_outputs();
    check("cnt_clr", cnt_clr, x_clr);
    check("cnt_tick", cnt_tick, x_tick);
    check("cnt_up", cnt_up, x_up);
    check("load_min", load_min, x_load);
    check("load_min_ones", load_min_ones, x_lo);
    check("load_min_tens", load_min_tens, x_lt);
    check("state_run", state_run, x_run);
    if (cnt_tick) begin
      obs_tick++;
      if (clr_cyc >= 0 && tick_after_clr < 0) tick_after_clr = cyc;
    end
    if (cnt_clr) begin
      obs_clr++; clr_cyc = cyc; tick_after_clr = -1;
    end
    if (load_min) begin
      obs_load++; load_cyc = cyc; obs_lo = int'(load_min_ones); obs_lt = int'(load_min_tens);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_clr"}, cnt_clr, 0);
    check({pfx, "_tick"}, cnt_tick, 0);
    check({pfx, "_up"}, cnt_up, 0);
    check({pfx, "_load"}, load_min, 0);
    check({pfx, "_lo"}, load_min_ones, 0);
    check({pfx, "_lt"}, load_min_tens, 0);
    check({pfx, "_run"}, state_run, 0);
  endtask

  initial begin
    int rise_cyc;
    bit found;
    bit bounce[8];
    bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    model_reset();
    clear_obs();

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();

    // Enable, count up from 00:00
    dip_enable = 1'b1; dip_up = 1'b1; t = 0;
    run(3);
    check("run_after_enable", state_run, 1);
    clear_obs();
    run(16);
    check("tick_count_16", obs_tick, 4);
    check("no_clr_run", obs_clr, 0);
    check("no_load_run", obs_load, 0);

    // Terminal 59:59 going up, then direction change resumes
    t = 3599;
    clear_obs();
    run(8);
    check("done_no_tick", obs_tick, 0);
    check("done_not_run", state_run, 0);
    dip_up = 1'b0;
    run(6);
    check("resume_run", state_run, 1);
    clear_obs();
    run(8);
    check("resume_ticks", obs_tick, 2);

    // Add5 with bounce at 57:xx saturates to 59
    t = 57 * 60 + 30;
    clear_obs();
    rise_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      push_add5 = bounce[i];
      if (i == 3) rise_cyc = cyc;
      step_cycle();
    end
    push_add5 = 1'b0;
    run(6);
    check("add5_once", obs_load, 1);
    check("add5_latency", load_cyc - rise_cyc, 6);
    check("add5_sat_tens", obs_lt, 5);
    check("add5_sat_ones", obs_lo, 9);

    // Add5 at 12:xx loads 17
    t = 12 * 60 + 30;
    clear_obs();
    push_add5 = 1'b1;
    run(5);
    push_add5 = 1'b0;
    run(6);
    check("add5_12_once", obs_load, 1);
    check("add5_12_tens", obs_lt, 1);
    check("add5_12_ones", obs_lo, 7);

    // Both buttons together: clear wins, prescaler restarts
    dip_up = 1'b1;
    run(4);
    clear_obs();
    push_reset = 1'b1; push_add5 = 1'b1;
    run(5);
    push_reset = 1'b0; push_add5 = 1'b0;
    run(10);
    check("both_clr_once", obs_clr, 1);
    check("both_no_load", obs_load, 0);
    check("tick_after_clear", tick_after_clr - clr_cyc, 4);

    // Short press rejected, long press accepted with fixed latency
    clear_obs();
    push_reset = 1'b1;
    run(2);
    push_reset = 1'b0;
    run(8);
    check("short_press_ignored", obs_clr, 0);
    clear_obs();
    push_reset = 1'b1;
    rise_cyc = cyc;
    run(6);
    push_reset = 1'b0;
    run(8);
    check("long_press_once", obs_clr, 1);
    check("long_press_latency", clr_cyc - rise_cyc, 6);

    // Async reset in the ADD cycle
    push_add5 = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step_cycle();
      if (load_min) found = 1'b1;
    end
    check("add_cycle_reached", found, 1);
    reset = 1'b1;
    push_add5 = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_obs();
    run(20);
    check("post_reset_no_clr", obs_clr, 0);
    check("post_reset_no_load", obs_load, 0);
    check("post_reset_run", state_run, 1);

    // Random switch/button activity against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) dip_enable = ~dip_enable;
      if ($urandom_range(59) == 0) dip_up = ~dip_up;
      if ($urandom_range(19) == 0) push_reset = ~push_reset;
      if ($urandom_range(15) == 0) push_add5 = ~push_add5;
      if ($urandom_range(149) == 0) begin
        case ($urandom_range(4))
          0: t = 0;
          1: t = 3599;
          2: t = 3599 - int'($urandom_range(3));
          3: t = 57 * 60 + int'($urandom_range(59));
          default: t = int'($urandom_range(3599));
        endcase
      end
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
